// File: rtl/otter_uart_pkg.sv
// Shared 8N1 UART definitions, intended for reuse by a matching receiver.
package otter_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int FRAME_BITS           = 10;
    localparam int DATA_BITS            = 8;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/otter_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, only pointers and count.
module otter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == FULL_COUNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/otter_uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO; the serial output is registered.
//   state    | meaning
//   ST_IDLE  | line high, waiting for a FIFO entry
//   ST_START | start bit (low)
//   ST_DATA  | eight data bits, LSB first
//   ST_STOP  | stop bit (high); chains straight into ST_START if FIFO non-empty
module otter_uart_tx
    import otter_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [7:0]                    TX_DATA,
    input  logic                          TX_VALID,
    output logic                          TX_READY,
    output logic                          TX_SERIAL,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        fifo_full, fifo_empty, fifo_pop, bit_done;
    logic [7:0]  fifo_head;

    otter_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_n_i     (RST_N),
        .push_i      (TX_VALID && TX_READY),
        .push_data_i (TX_DATA),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (FIFO_COUNT)
    );

    assign TX_READY  = !fifo_full;
    assign TX_SERIAL = tx_q;
    assign BUSY      = (state_q != ST_IDLE) || !fifo_empty;
    assign bit_done  = (cnt_q == CNT_LAST);
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        if (state_q != ST_IDLE) cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    state_d = ST_START;
                    shift_d = fifo_head;
                end
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (fifo_pop) begin
                        state_d = ST_START;
                        shift_d = fifo_head;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line follows the state one cycle later; every bit still lasts CLKS_PER_BIT cycles.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_otter_uart_tx.sv
// Self-checking bench for otter_uart_tx against a frame-level reference model.
module tb_otter_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_VALID = 1'b0;
    logic       TX_READY, TX_SERIAL, BUSY;
    logic [2:0] FIFO_COUNT;

    int total = 0;
    int bad   = 0;

    otter_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .TX_SERIAL  (TX_SERIAL),
        .BUSY       (BUSY),
        .FIFO_COUNT (FIFO_COUNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: queue of accepted bytes plus the pop edge of the frame on the line.
    logic [7:0] mq[$];
    int         edge_n = 0;
    int         fr_pop = -1000;
    int         fr_end = 0;
    logic [7:0] fr_byte = 8'h00;
    logic       exp_line = 1'b1, exp_busy = 1'b0, exp_ready = 1'b1;
    logic [2:0] exp_count = 3'd0;

    wire [5:0] obs  = {TX_SERIAL, BUSY, TX_READY, FIFO_COUNT};
    wire [5:0] expv = {exp_line, exp_busy, exp_ready, exp_count};

    task automatic step();
        int cnt_pre;
        int slot;
        @(posedge CLK);
        edge_n++;
        if (!RST_N) begin
            mq.delete();
            fr_pop = -1000;
            fr_end = edge_n;
        end else begin
            cnt_pre = mq.size();
            if (edge_n >= fr_end && cnt_pre > 0) begin
                fr_byte = mq.pop_front();
                fr_pop  = edge_n;
                fr_end  = edge_n + 10 * CPB;
            end
            if (TX_VALID && cnt_pre != DEPTH) mq.push_back(TX_DATA);
        end
        if (edge_n > fr_pop && edge_n <= fr_pop + 10 * CPB) begin
            slot = (edge_n - fr_pop - 1) / CPB;
            if (slot == 0)      exp_line = 1'b0;
            else if (slot <= 8) exp_line = fr_byte[slot-1];
            else                exp_line = 1'b1;
        end else begin
            exp_line = 1'b1;
        end
        exp_busy  = (edge_n < fr_end) || (mq.size() != 0);
        exp_ready = (mq.size() != DEPTH);
        exp_count = 3'(mq.size());
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        TX_VALID = 1'b0;
        repeat (3) step();
        total++;
        if (obs !== 6'b101000) begin
            bad++;
            $display("FAIL reset_hold got=%b want=%b", obs, 6'b101000);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (obs !== 6'b101000) begin
                bad++;
                $display("FAIL reset_release cyc=%0d got=%b want=%b", i, obs, 6'b101000);
            end
        end
    endtask

    task automatic test_single();
        logic [9:0] fv;
        logic       line_log[64];
        logic       busy_log[64];
        fv = {1'b1, 8'hA5, 1'b0};
        TX_DATA = 8'hA5;
        TX_VALID = 1'b1;
        step();
        TX_VALID = 1'b0;
        total++;
        if (FIFO_COUNT !== 3'd1) begin
            bad++;
            $display("FAIL single_accept_count got=%0d want=1", FIFO_COUNT);
        end
        for (int i = 1; i <= 45; i++) begin
            step();
            line_log[i] = TX_SERIAL;
            busy_log[i] = BUSY;
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL single_model cyc=%0d got=%b want=%b", i, obs, expv);
            end
        end
        total++;
        if (line_log[1] !== 1'b1) begin
            bad++;
            $display("FAIL single_pre_start got=%b want=1", line_log[1]);
        end
        for (int i = 2; i <= 41; i++) begin
            total++;
            if (line_log[i] !== fv[(i-2)/CPB]) begin
                bad++;
                $display("FAIL single_bit cyc=%0d got=%b want=%b", i, line_log[i], fv[(i-2)/CPB]);
            end
        end
        total++;
        if ({busy_log[40], busy_log[41], line_log[42]} !== 3'b101) begin
            bad++;
            $display("FAIL single_busy_fall got=%b want=101",
                     {busy_log[40], busy_log[41], line_log[42]});
        end
    endtask

    task automatic test_back_to_back();
        int peak = 0;
        for (int i = 0; i < 128; i++) begin
            TX_VALID = (i < 3);
            TX_DATA  = 8'(i + 1);
            step();
            if (int'(FIFO_COUNT) > peak) peak = int'(FIFO_COUNT);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL b2b_model cyc=%0d got=%b want=%b", i, obs, expv);
            end
        end
        TX_VALID = 1'b0;
        total++;
        if (peak != 2) begin
            bad++;
            $display("FAIL b2b_peak_count got=%0d want=2", peak);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes[6];
        int acc = 0;
        int cyc = 0;
        bit saw_block = 0;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        while (acc < 6 && cyc < 400) begin
            TX_VALID = 1'b1;
            if (TX_READY) begin
                TX_DATA = bytes[acc];
                acc++;
            end else begin
                TX_DATA = 8'($urandom);
            end
            step();
            cyc++;
            if (FIFO_COUNT == 3'd4 && TX_READY == 1'b0) saw_block = 1;
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL overflow_model cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        TX_VALID = 1'b0;
        total++;
        if (acc != 6) begin
            bad++;
            $display("FAIL overflow_timeout accepted=%0d want=6", acc);
        end
        total++;
        if (!saw_block) begin
            bad++;
            $display("FAIL overflow_ready_low got=0 want=1");
        end
        for (int i = 0; i < 300; i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL overflow_drain cyc=%0d got=%b want=%b", i, obs, expv);
            end
        end
    endtask

    task automatic test_full_push_pop();
        int   acc = 0;
        int   cyc = 0;
        logic ready_before = 1'b1;
        logic [2:0] cnt_before = 3'd0;
        bit   changed = 0;
        while (acc < 5 && cyc < 100) begin
            TX_VALID = 1'b1;
            if (TX_READY) begin
                TX_DATA = 8'(8'h81 + acc);
                acc++;
            end
            step();
            cyc++;
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL fullpp_fill cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        TX_DATA = 8'hEE;
        cyc = 0;
        while (!changed && cyc < 60) begin
            ready_before = TX_READY;
            cnt_before   = FIFO_COUNT;
            step();
            cyc++;
            changed = (FIFO_COUNT != cnt_before);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL fullpp_model cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        TX_VALID = 1'b0;
        total++;
        if ({ready_before, cnt_before, FIFO_COUNT} !== {1'b0, 3'd4, 3'd3}) begin
            bad++;
            $display("FAIL fullpp_reject got=%b/%0d->%0d want=0/4->3",
                     ready_before, cnt_before, FIFO_COUNT);
        end
        for (int i = 0; i < 260; i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL fullpp_drain cyc=%0d got=%b want=%b", i, obs, expv);
            end
        end
    endtask

    task automatic test_zero_ff();
        logic want;
        for (int i = 0; i < 100; i++) begin
            TX_VALID = (i < 2);
            TX_DATA  = (i == 0) ? 8'h00 : 8'hFF;
            step();
            want = ((i >= 2 && i <= 37) || (i >= 42 && i <= 45)) ? 1'b0 : 1'b1;
            total++;
            if (TX_SERIAL !== want) begin
                bad++;
                $display("FAIL zero_ff_line cyc=%0d got=%b want=%b", i, TX_SERIAL, want);
            end
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL zero_ff_model cyc=%0d got=%b want=%b", i, obs, expv);
            end
        end
        TX_VALID = 1'b0;
    endtask

    task automatic test_reset_midframe();
        TX_VALID = 1'b1;
        TX_DATA  = 8'h3C;
        step();
        TX_DATA  = 8'h5A;
        step();
        TX_VALID = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL midrst_pre cyc=%0d got=%b want=%b", i, obs, expv);
            end
        end
        #2 RST_N = 1'b0;
        #1;
        total++;
        if (obs !== 6'b101000) begin
            bad++;
            $display("FAIL midrst_async got=%b want=%b", obs, 6'b101000);
        end
        repeat (2) step();
        RST_N = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            total++;
            if (obs !== 6'b101000) begin
                bad++;
                $display("FAIL midrst_after cyc=%0d got=%b want=%b", i, obs, 6'b101000);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            TX_VALID = ($urandom_range(0, 99) < 35);
            TX_DATA  = 8'($urandom);
            if (i == 400) RST_N = 1'b0;
            if (i == 403) RST_N = 1'b1;
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%b want=%b", i, obs, expv);
            end
        end
        TX_VALID = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random_drain cyc=%0d got=%b want=%b", i, obs, expv);
            end
        end
        total++;
        if (BUSY !== 1'b0) begin
            bad++;
            $display("FAIL random_idle_end got=%b want=0", BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_zero_ff();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
